risc_v_mike_gpio_ctrl: RTL and testbench

Parametrised, memory-mapped GPIO controller for the risc_v_mike core. It replaces the fixed single-byte gpio_port_in/gpio_port_out pair with NUM_PORTS ports of PORT_WIDTH pins each. Each pin has direction control, 2-flop input synchronisation, rising-edge capture and a maskable interrupt. It sits on the core's data-memory bus alongside RAM and is instantiated in risc_v_mike_top.

---
 rtl/risc_v_mike_pkg.sv | 26 ++
 rtl/risc_v_mike_gpio_port.sv | 102 ++++++++++
 rtl/risc_v_mike_gpio_ctrl.sv | 146 ++++++++++++++
 tb/tb_risc_v_mike_gpio_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_pkg.sv
// Shared definitions for the risc_v_mike GPIO controller: register offsets,
// window geometry and the bus request payload.
package risc_v_mike_pkg;

    localparam int unsigned GPIO_PORT_STRIDE = 32'h20;
    localparam int unsigned GPIO_WIN_BITS    = 8;
    localparam int unsigned GPIO_REG_BITS    = $clog2(GPIO_PORT_STRIDE);
    localparam int unsigned GPIO_PIDX_BITS   = GPIO_WIN_BITS - GPIO_REG_BITS;
    localparam int unsigned GPIO_BUS_W       = 32;

    typedef enum logic [GPIO_REG_BITS-1:0] {
        GPIO_OUT       = 5'h00,
        GPIO_DIR       = 5'h04,
        GPIO_IN        = 5'h08,
        GPIO_IRQ_EN    = 5'h0C,
        GPIO_EDGE_STAT = 5'h10
    } gpio_reg_e;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [GPIO_BUS_W-1:0] addr;
        logic [GPIO_BUS_W-1:0] wdata;
    } gpio_bus_t;

endpackage

// File: rtl/risc_v_mike_gpio_port.sv
// One GPIO port: OUT/DIR/IRQ_EN registers, 2-flop input synchroniser,
// rising-edge capture with W1C status. Optional filter: GPIO_DEBOUNCE_EN.
module risc_v_mike_gpio_port
    import risc_v_mike_pkg::*;
#(
    parameter int unsigned PORT_WIDTH      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_out,
    input  logic                  i_wr_dir,
    input  logic                  i_wr_irq_en,
    input  logic                  i_wr_clr,
    input  logic [PORT_WIDTH-1:0] i_wdata,
    input  logic                  i_armed,
    input  logic [PORT_WIDTH-1:0] i_pad,
    output logic [PORT_WIDTH-1:0] o_out,
    output logic [PORT_WIDTH-1:0] o_dir,
    output logic [PORT_WIDTH-1:0] o_in,
    output logic [PORT_WIDTH-1:0] o_irq_en,
    output logic [PORT_WIDTH-1:0] o_edge_stat,
    output logic                  o_irq_c
);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_err
        $error("risc_v_mike_gpio_port: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [PORT_WIDTH-1:0] r_out;
    logic [PORT_WIDTH-1:0] r_dir;
    logic [PORT_WIDTH-1:0] r_irq_en;
    logic [PORT_WIDTH-1:0] r_edge;
    logic [PORT_WIDTH-1:0] r_sync1;
    logic [PORT_WIDTH-1:0] r_sync2;
    logic [PORT_WIDTH-1:0] r_prev;
    logic [PORT_WIDTH-1:0] w_in;
    logic [PORT_WIDTH-1:0] w_rise;
    logic [PORT_WIDTH-1:0] w_clr;

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [PORT_WIDTH-1:0] r_filt;
    logic [CNT_W-1:0]      r_db_cnt [PORT_WIDTH];

    // Filtered value follows sync2 only after it has disagreed for DEBOUNCE_CYCLES in a row
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < PORT_WIDTH; i++) begin
            if (rst) begin
                r_filt[i]   <= 1'b0;
                r_db_cnt[i] <= '0;
            end else if (r_sync2[i] != r_filt[i]) begin
                if (r_db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt[i]   <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end else begin
                r_db_cnt[i] <= '0;
            end
        end
    end

    assign w_in = r_filt;
`else
    assign w_in = r_sync2;
`endif

    assign w_rise = w_in & ~r_prev & {PORT_WIDTH{i_armed}};
    assign w_clr  = i_wr_clr ? i_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_dir    <= '0;
            r_irq_en <= '0;
            r_edge   <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
        end else begin
            if (i_wr_out)    r_out    <= i_wdata;
            if (i_wr_dir)    r_dir    <= i_wdata;
            if (i_wr_irq_en) r_irq_en <= i_wdata;
            // A new edge in the same cycle as a clear keeps the bit set
            r_edge  <= (r_edge & ~w_clr) | w_rise;
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
            r_prev  <= w_in;
        end
    end

    assign o_out       = r_out;
    assign o_dir       = r_dir;
    assign o_in        = w_in;
    assign o_irq_en    = r_irq_en;
    assign o_edge_stat = r_edge;
    assign o_irq_c     = |(r_edge & r_irq_en);

endmodule

// File: rtl/risc_v_mike_gpio_ctrl.sv
// Memory-mapped multi-port GPIO controller: address decode, registered read
// mux, interrupt OR and post-reset edge arming. Optional filter: GPIO_DEBOUNCE_EN.
module risc_v_mike_gpio_ctrl
    import risc_v_mike_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned PORT_WIDTH      = 8,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bus_req,
    input  logic                            bus_we,
    input  logic [31:0]                     bus_addr,
    input  logic [31:0]                     bus_wdata,
    output logic [31:0]                     bus_rdata,
    output logic                            bus_rvalid,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_port_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_port_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_port_oe,
    output logic                            irq
);

    localparam int unsigned PW = PORT_WIDTH;

    if (NUM_PORTS < 1 || NUM_PORTS > 8 || PORT_WIDTH < 1 || PORT_WIDTH > 32 ||
        BASE_ADDR[GPIO_WIN_BITS-1:0] != '0) begin : g_param_err
        $error("risc_v_mike_gpio_ctrl: parameter out of range");
    end

    gpio_bus_t                 w_bus;
    logic                      w_sel;
    logic                      w_wr_hit;
    logic                      w_rd_hit;
    logic [GPIO_PIDX_BITS-1:0] w_pidx;
    logic [GPIO_REG_BITS-1:0]  w_roff;
    logic [PW-1:0]             w_wdata;
    logic [NUM_PORTS-1:0]      w_wr_out;
    logic [NUM_PORTS-1:0]      w_wr_dir;
    logic [NUM_PORTS-1:0]      w_wr_irq_en;
    logic [NUM_PORTS-1:0]      w_wr_clr;
    logic [NUM_PORTS-1:0]      w_irq_src;
    logic [PW-1:0]             w_in        [NUM_PORTS];
    logic [PW-1:0]             w_irq_en    [NUM_PORTS];
    logic [PW-1:0]             w_edge_stat [NUM_PORTS];
    logic [31:0]               w_rd_data;
    logic                      w_armed;
    logic                      w_unused_bits;

    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_irq;
    logic [1:0]  r_arm_cnt;

    assign w_bus = '{req: bus_req, we: bus_we, addr: bus_addr, wdata: bus_wdata};

    // Word offset within a port; byte-lane bits are dropped
    assign w_sel    = w_bus.req && (w_bus.addr[31:GPIO_WIN_BITS] == BASE_ADDR[31:GPIO_WIN_BITS]);
    assign w_wr_hit = w_sel && w_bus.we;
    assign w_rd_hit = w_sel && !w_bus.we;
    assign w_pidx   = w_bus.addr[GPIO_WIN_BITS-1:GPIO_REG_BITS];
    assign w_roff   = {w_bus.addr[GPIO_REG_BITS-1:2], 2'b00};
    assign w_wdata  = w_bus.wdata[PW-1:0];
    assign w_armed  = (r_arm_cnt == 2'd3);

    assign w_unused_bits = ^{w_bus.addr[1:0], w_bus.wdata};

    always_comb begin
        w_wr_out    = '0;
        w_wr_dir    = '0;
        w_wr_irq_en = '0;
        w_wr_clr    = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_wr_hit && (w_pidx == GPIO_PIDX_BITS'(p))) begin
                case (w_roff)
                    GPIO_OUT:       w_wr_out[p]    = 1'b1;
                    GPIO_DIR:       w_wr_dir[p]    = 1'b1;
                    GPIO_IRQ_EN:    w_wr_irq_en[p] = 1'b1;
                    GPIO_EDGE_STAT: w_wr_clr[p]    = 1'b1;
                    default:        ;
                endcase
            end
        end
    end

    // Unmapped offsets and absent ports fall through to zero
    always_comb begin
        w_rd_data = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_pidx == GPIO_PIDX_BITS'(p)) begin
                case (w_roff)
                    GPIO_OUT:       w_rd_data = 32'(gpio_port_out[p*PW +: PW]);
                    GPIO_DIR:       w_rd_data = 32'(gpio_port_oe[p*PW +: PW]);
                    GPIO_IN:        w_rd_data = 32'(w_in[p]);
                    GPIO_IRQ_EN:    w_rd_data = 32'(w_irq_en[p]);
                    GPIO_EDGE_STAT: w_rd_data = 32'(w_edge_stat[p]);
                    default:        w_rd_data = '0;
                endcase
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        risc_v_mike_gpio_port #(
            .PORT_WIDTH      (PORT_WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .i_wr_out    (w_wr_out[p]),
            .i_wr_dir    (w_wr_dir[p]),
            .i_wr_irq_en (w_wr_irq_en[p]),
            .i_wr_clr    (w_wr_clr[p]),
            .i_wdata     (w_wdata),
            .i_armed     (w_armed),
            .i_pad       (gpio_port_in[p*PW +: PW]),
            .o_out       (gpio_port_out[p*PW +: PW]),
            .o_dir       (gpio_port_oe[p*PW +: PW]),
            .o_in        (w_in[p]),
            .o_irq_en    (w_irq_en[p]),
            .o_edge_stat (w_edge_stat[p]),
            .o_irq_c     (w_irq_src[p])
        );
    end

    // Arming counter holds off edge capture while the input pipeline refills
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_irq     <= 1'b0;
            r_arm_cnt <= 2'd0;
        end else begin
            r_rvalid <= w_rd_hit;
            if (w_rd_hit) r_rdata <= w_rd_data;
            r_irq <= |w_irq_src;
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;
        end
    end

    assign bus_rdata  = r_rdata;
    assign bus_rvalid = r_rvalid;
    assign irq        = r_irq;

endmodule

// File: tb/tb_risc_v_mike_gpio_ctrl.sv
// Scoreboard bench for risc_v_mike_gpio_ctrl: reads queue their expected data,
// a negedge monitor checks every rvalid against the queue head.
module tb_risc_v_mike_gpio_ctrl;

    localparam int NP = 2;
    localparam int PW = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif

    localparam logic [7:0] O_OUT  = 8'h00;
    localparam logic [7:0] O_DIR  = 8'h04;
    localparam logic [7:0] O_IN   = 8'h08;
    localparam logic [7:0] O_EN   = 8'h0C;
    localparam logic [7:0] O_EDGE = 8'h10;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              bus_req;
    logic              bus_we;
    logic [31:0]       bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_rvalid;
    logic [NP*PW-1:0]  gpio_in;
    logic [NP*PW-1:0]  gpio_out;
    logic [NP*PW-1:0]  gpio_oe;
    logic              irq;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    risc_v_mike_gpio_ctrl #(
        .NUM_PORTS       (NP),
        .PORT_WIDTH      (PW),
        .BASE_ADDR       (32'h0000_1000),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_rvalid    (bus_rvalid),
        .gpio_port_in  (gpio_in),
        .gpio_port_out (gpio_out),
        .gpio_port_oe  (gpio_oe),
        .irq           (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] A(input int p, input logic [7:0] off);
        return 32'h0000_1000 + 32'(p) * 32'h20 + 32'(off);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus_req = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) idle();
    endtask

    task automatic issue_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
    endtask

    task automatic issue_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = addr;
        e.data = exp;
        e.due  = cyc + 1;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: every rvalid must match the queue head, exactly one cycle after issue
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: no rvalid at cycle %0d, required data %h", e.name, e.due, e.data);
        end
        if (bus_rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata %h, required no rvalid", bus_rdata);
            end else begin
                e = sb_q.pop_front();
                check(e.name, bus_rdata, e.data);
                check({e.name, "_lat"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        gpio_in   = '0;

        // 1: reset state
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(4);
        check("rst_oe", 32'(gpio_oe), 32'h0);
        check("rst_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        issue_read(A(0, O_DIR), 32'h0, "rst_dir0");
        issue_read(A(0, O_OUT), 32'h0, "rst_out0");
        issue_read(A(0, O_EDGE), 32'h0, "rst_edge0");
        idle();
        issue_read(32'h0000_2000, 32'h0, "outside_window");
        sb_q.pop_back();
        wait_cyc(2);

        // 2: OUT/DIR of port 1, port 0 untouched; upper write bits dropped
        issue_write(A(1, O_OUT), 32'h0000_00A5);
        issue_write(A(1, O_DIR), 32'h0000_00FF);
        idle();
        check("p1_out_pads", 32'(gpio_out), 32'h0000_A500);
        check("p1_oe_pads", 32'(gpio_oe), 32'h0000_FF00);
        issue_read(A(1, O_OUT), 32'h0000_00A5, "rd_out1");
        issue_read(A(1, O_DIR), 32'h0000_00FF, "rd_dir1");
        issue_write(A(0, O_OUT), 32'hFFFF_FF5A);
        issue_write(A(0, O_IN), 32'h0000_00FF);
        issue_read(A(0, O_OUT), 32'h0000_005A, "rd_out0_trunc");
        issue_read(A(0, O_IN), 32'h0, "rd_in0_ro");
        idle();
        check("p0_out_pads", 32'(gpio_out), 32'h0000_A55A);

        // 3: rising edge on pin 3 of port 0 with IRQ_EN=0x08
        issue_write(A(0, O_EN), 32'h0000_0008);
        wait_cyc(2);
        gpio_in[3] = 1'b1;
        wait_cyc(DB);
        issue_read(A(0, O_IN), 32'h0, "in_k1");
        issue_read(A(0, O_IN), 32'h0000_0008, "in_k2");
        issue_read(A(0, O_EDGE), 32'h0000_0008, "edge_k3");
        check("irq_k2", 32'(irq), 32'h0);
        idle();
        check("irq_k3", 32'(irq), 32'h1);
        wait_cyc(2);
        issue_write(A(0, O_EDGE), 32'h0000_0008);
        idle();
        check("irq_clr_edge", 32'(irq), 32'h1);
        idle();
        check("irq_after_clr", 32'(irq), 32'h0);
        issue_read(A(0, O_EDGE), 32'h0, "edge_cleared");
        wait_cyc(2);

        // 4: clear and new edge in the same cycle, set wins
        gpio_in[3] = 1'b0;
        wait_cyc(DB + 4);
        gpio_in[3] = 1'b1;
        wait_cyc(DB + 4);
        gpio_in[3] = 1'b0;
        wait_cyc(DB + 4);
        issue_read(A(0, O_EDGE), 32'h0000_0008, "edge_pre_race");
        idle();
        gpio_in[3] = 1'b1;
        wait_cyc(DB);
        idle();
        issue_write(A(0, O_EDGE), 32'h0000_0008);
        idle();
        issue_read(A(0, O_EDGE), 32'h0000_0008, "edge_set_wins");
        issue_write(A(0, O_EDGE), 32'h0000_0008);
        issue_read(A(0, O_EDGE), 32'h0, "edge_clr_again");
        wait_cyc(3);
        check("irq_idle", 32'(irq), 32'h0);

        // Masked edge on port 1 pin 0, then unmask and re-mask
        gpio_in[8] = 1'b1;
        wait_cyc(DB + 5);
        check("irq_masked", 32'(irq), 32'h0);
        issue_read(A(1, O_EDGE), 32'h0000_0001, "edge_p1_masked");
        issue_write(A(1, O_EN), 32'h0000_0001);
        idle();
        check("irq_unmask_t1", 32'(irq), 32'h0);
        idle();
        check("irq_unmask_t2", 32'(irq), 32'h1);
        issue_write(A(1, O_EN), 32'h0000_0000);
        idle();
        check("irq_mask_t1", 32'(irq), 32'h1);
        idle();
        check("irq_mask_t2", 32'(irq), 32'h0);

        // 5: pins high through reset, reset drops a pending read
        gpio_in = '1;
        @(negedge clk);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = A(0, O_OUT);
        rst      = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(8 + DB);
        check("rst2_irq", 32'(irq), 32'h0);
        check("rst2_out", 32'(gpio_out), 32'h0);
        check("rst2_oe", 32'(gpio_oe), 32'h0);
        issue_read(A(0, O_EDGE), (DB > 0) ? 32'hFF : 32'h0, "edge_after_rst_p0");
        issue_read(A(1, O_EDGE), (DB > 0) ? 32'hFF : 32'h0, "edge_after_rst_p1");
        issue_read(A(0, O_IN), 32'h0000_00FF, "in_high_p0");
        issue_read(A(1, O_IN), 32'h0000_00FF, "in_high_p1");
        issue_read(A(0, 8'h14), 32'h0, "unmapped_0x14");
        issue_read(A(NP, O_OUT), 32'h0, "port_out_of_range");
        issue_read(A(7, O_EN), 32'h0, "port7_irq_en");
        idle();

`ifdef GPIO_DEBOUNCE_EN
        // 6: short pulse filtered out, long pulse captured
        gpio_in = '0;
        wait_cyc(40);
        issue_write(A(0, O_EDGE), 32'h0000_00FF);
        idle();
        gpio_in[4] = 1'b1;
        wait_cyc(10);
        gpio_in[4] = 1'b0;
        wait_cyc(40);
        issue_read(A(0, O_EDGE), 32'h0, "db_short_pulse");
        issue_read(A(0, O_IN), 32'h0, "db_short_in");
        gpio_in[4] = 1'b1;
        wait_cyc(20);
        gpio_in[4] = 1'b0;
        wait_cyc(40);
        issue_read(A(0, O_EDGE), 32'h0000_0010, "db_long_pulse");
        idle();
`endif

        wait_cyc(3);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
